// File: rtl/stim_pkg.sv
// stim_pkg: definitions shared by the stimulation slot scheduler.
//   state_t           - scheduler FSM states, exposed on the top-level debug port
//   DEFAULT_DEAD_TIME - default dead-time around mux switching, in clk cycles
//   DEFAULT_TIMEOUT   - default watchdog limit, in clk cycles
//   MAX_NCH           - widest supported channel count
//   onehot()          - index to one-hot vector, MAX_NCH bits wide
package stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRE_GUARD  = 3'd1,
    ST_RUN        = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_POST_GUARD = 3'd4,
    ST_FAULT      = 3'd5
  } state_t;

  localparam int DEFAULT_DEAD_TIME = 20;
  localparam int DEFAULT_TIMEOUT   = 6000000;
  localparam int MAX_NCH           = 16;

  function automatic logic [MAX_NCH-1:0] onehot(input logic [3:0] idx);
    logic [MAX_NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Returns the first set req bit at or after ptr, wrapping modulo NCH.
//   req    in  NCH          request vector
//   ptr    in  $clog2(NCH)  highest-priority index for this pick
//   winner out $clog2(NCH)  granted index (0 when valid is low)
//   valid  out 1            at least one request is set
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [$clog2(NCH)-1:0] winner,
  output logic                   valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester
  // (smallest offset from ptr) is the last to overwrite winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (req[idx]) begin
        winner = ($clog2(NCH))'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stim_slot_scheduler.sv
// stim_slot_scheduler: time-shares one triphasic pulse generator between NCH
// electrode channels. A round-robin grant connects one channel through a
// one-hot mux, with DEAD_TIME cycles of generator-off either side of the
// connection, and runs the generator for PULSES_PER_SLOT completed pulses.
//
// Ports:
//   clk        in  1            system clock
//   reset      in  1            synchronous, active-low reset
//   req        in  NCH          per-channel request, level-sensitive
//   gen_a      in  1            generator A output (positive phases)
//   gen_b      in  1            generator B output (negative phase)
//   gen_c      in  1            generator C output (grounded / idle)
//   gen_enable out 1            generator enable
//   ch_sel     out NCH          one-hot mux select, all-zero = disconnected
//   busy       out 1            high in every state except IDLE
//   slot_done  out 1            one-cycle pulse when a slot finishes
//   slot_ch    out $clog2(NCH)  channel of the finished slot, valid with slot_done
//   fault      out 1            watchdog fault (0 unless STIM_WATCHDOG_EN)
//   state_dbg  out state_t      current FSM state
//
// Request semantics: req[i] is a level. It is sampled for arbitration only in
// IDLE; once granted, req[winner] falling asks the slot to end after the
// pulse in progress. There is no separate acknowledge beyond ch_sel/slot_done.
//
// Optional build: define STIM_WATCHDOG_EN to add a watchdog that forces the
// FAULT state (left only by reset) when no pulse completes within TIMEOUT
// cycles of RUN/DRAIN, or when gen_a and gen_b are seen high together.
module stim_slot_scheduler
  import stim_pkg::*;
#(
  parameter int NCH             = 4,
  parameter int PULSES_PER_SLOT = 8,
  parameter int DEAD_TIME       = DEFAULT_DEAD_TIME,
  parameter int CNT_W           = 16,
  parameter int TIMEOUT         = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic                   gen_a,
  input  logic                   gen_b,
  input  logic                   gen_c,
  output logic                   gen_enable,
  output logic [NCH-1:0]         ch_sel,
  output logic                   busy,
  output logic                   slot_done,
  output logic [$clog2(NCH)-1:0] slot_ch,
  output logic                   fault,
  output state_t                 state_dbg
);

  localparam int IW = $clog2(NCH);

  state_t               state;
  logic [IW-1:0]        winner;
  logic [IW-1:0]        rr_ptr;
  logic [CNT_W-1:0]     guard_cnt;
  logic [CNT_W-1:0]     pulse_cnt;
  logic                 neg_seen;
  logic                 a_prev;
  logic                 quiet_seen;

  logic [IW-1:0]        arb_winner;
  logic                 arb_valid;
  logic [MAX_NCH-1:0]   arb_onehot;

  logic                 win_req;
  logic                 pulse_done;
  logic                 last_pulse;
  logic                 quiet;
  logic                 guard_end;
  logic                 wd_trip;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  assign arb_onehot = onehot(4'(arb_winner));
  assign win_req    = req[winner];
  // A pulse is complete when gen_a falls after a negative phase was seen.
  assign pulse_done = a_prev & ~gen_a & neg_seen;
  assign last_pulse = (pulse_cnt >= CNT_W'(PULSES_PER_SLOT - 1));
  assign quiet      = gen_c & ~gen_a & ~gen_b;
  assign guard_end  = (guard_cnt >= CNT_W'(DEAD_TIME - 1));
  assign state_dbg  = state;

`ifdef STIM_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = (state == ST_RUN) || (state == ST_DRAIN);
  assign wd_trip   = wd_active &&
                     ((wd_cnt >= WD_W'(TIMEOUT - 1)) || (gen_a && gen_b));

  // Counts cycles spent in RUN/DRAIN since the last completed pulse.
  always_ff @(posedge clk) begin
    if (!reset || !wd_active || (state == ST_RUN && pulse_done))
      wd_cnt <= '0;
    else if (wd_cnt != {WD_W{1'b1}})
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_trip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      winner     <= '0;
      rr_ptr     <= '0;
      guard_cnt  <= '0;
      pulse_cnt  <= '0;
      neg_seen   <= 1'b0;
      a_prev     <= 1'b0;
      quiet_seen <= 1'b0;
      gen_enable <= 1'b0;
      ch_sel     <= '0;
      busy       <= 1'b0;
      slot_done  <= 1'b0;
      slot_ch    <= '0;
      fault      <= 1'b0;
    end else begin
      a_prev    <= gen_a;
      slot_done <= 1'b0;

      if (wd_trip) begin
        // Disconnect at once; no drain or guard on a fault.
        state      <= ST_FAULT;
        gen_enable <= 1'b0;
        ch_sel     <= '0;
        fault      <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arb_valid) begin
              winner    <= arb_winner;
              ch_sel    <= arb_onehot[NCH-1:0];
              guard_cnt <= '0;
              busy      <= 1'b1;
              state     <= ST_PRE_GUARD;
            end
          end

          ST_PRE_GUARD: begin
            if (guard_end) begin
              guard_cnt  <= '0;
              pulse_cnt  <= '0;
              neg_seen   <= 1'b0;
              gen_enable <= 1'b1;
              state      <= ST_RUN;
            end else begin
              guard_cnt <= sat_inc(guard_cnt);
            end
          end

          ST_RUN: begin
            if (pulse_done) begin
              pulse_cnt <= sat_inc(pulse_cnt);
              neg_seen  <= 1'b0;
              if (last_pulse || !win_req) begin
                gen_enable <= 1'b0;
                quiet_seen <= 1'b0;
                state      <= ST_DRAIN;
              end
            end else begin
              // Both outputs high together is not a valid negative phase.
              if (gen_b && !gen_a) neg_seen <= 1'b1;
              // Early end with no pulse in flight: stop without waiting.
              if (!win_req && !neg_seen && !gen_a && !gen_b) begin
                gen_enable <= 1'b0;
                quiet_seen <= 1'b0;
                state      <= ST_DRAIN;
              end
            end
          end

          ST_DRAIN: begin
            // Needs two consecutive idle samples before moving the mux.
            if (quiet) begin
              quiet_seen <= 1'b1;
              if (quiet_seen) begin
                guard_cnt <= '0;
                state     <= ST_POST_GUARD;
              end
            end else begin
              quiet_seen <= 1'b0;
            end
          end

          ST_POST_GUARD: begin
            if (guard_end) begin
              ch_sel    <= '0;
              slot_done <= 1'b1;
              slot_ch   <= winner;
              rr_ptr    <= (winner == IW'(NCH - 1)) ? '0 : winner + 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              guard_cnt <= sat_inc(guard_cnt);
            end
          end

          ST_FAULT: begin
            gen_enable <= 1'b0;
            ch_sel     <= '0;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/stim_slot_scheduler.md
Name: stim_slot_scheduler

Overview:
- Time-shares one triphasic pulse generator between NCH electrode channels.
- Round-robin arbitrates channel requests and drives the generator's enable.
- Drives a one-hot channel-select mux, with dead-time guards either side of each connection.
- Counts completed triphasic pulses by monitoring the generator's A/B/C outputs; ends each slot after PULSES_PER_SLOT pulses.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- PULSES_PER_SLOT, 8, triphasic pulses delivered per grant (≥1).
- DEAD_TIME, 20, clk cycles with enable low before and after mux switching (≥1).
- CNT_W, 16, width of the dead-time/pulse counters.
- TIMEOUT, 6000000, watchdog limit in cycles without pulse completion. Must exceed the generator's LONG_GAP plus one pulse.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req  in  NCH  per-channel stimulation request, level-sensitive.
- gen_a  in  1  generator A output (positive phases).
- gen_b  in  1  generator B output (negative phase).
- gen_c  in  1  generator C output (electrode grounded / idle).
- gen_enable  out  1  generator enable.
- ch_sel  out  NCH  one-hot electrode mux select; all-zero means disconnected.
- busy  out  1  high in every state except IDLE.
- slot_done  out  1  one-cycle pulse when a slot finishes.
- slot_ch  out  $clog2(NCH)  index of the channel whose slot finished; valid with slot_done.
- fault  out  1  watchdog fault (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low; ports are named clk and reset. On the first clk edge with reset low, all outputs go to 0, state to IDLE, and the RR pointer to 0. Reset low mid-slot aborts immediately: enable and ch_sel drop on that edge, with no drain.
- States: IDLE, PRE_GUARD, RUN, DRAIN, POST_GUARD, FAULT.
- IDLE: if any req bit is high, latch winner = first requester at or after rr_ptr, wrapping modulo NCH. Set ch_sel = onehot(winner) and go to PRE_GUARD. Arbitration costs 1 cycle. If req is all zero, stay in IDLE.
- PRE_GUARD: gen_enable = 0, ch_sel held. Count DEAD_TIME cycles, then go to RUN.
- RUN: gen_enable = 1.
  - neg_seen is set on the cycle gen_b is high.
  - Pulse completion is a falling edge of gen_a (registered previous value) while neg_seen = 1; it increments pulse_cnt and clears neg_seen.
  - On the completion that makes pulse_cnt = PULSES_PER_SLOT, deassert gen_enable in the same cycle and go to DRAIN.
  - If req[winner] falls during RUN, the slot ends early: keep enable until the current pulse completes (or go straight to DRAIN if neg_seen = 0 and gen_a is low), then go to DRAIN.
- DRAIN: gen_enable = 0. Wait until gen_c = 1 and gen_a = gen_b = 0 for 2 consecutive cycles, then go to POST_GUARD.
- POST_GUARD: count DEAD_TIME cycles with ch_sel still held. On exit, clear ch_sel, pulse slot_done with slot_ch = winner, set rr_ptr = (winner+1) mod NCH, and return to IDLE.
- Worst-case latency from a new req to first enable: NCH slots plus (1 + DEAD_TIME) cycles.
- Counters saturate, never wrap.
- A req bit rising mid-slot is only sampled in IDLE.
- gen_a and gen_b both high in the same cycle counts as nothing toward pulse completion.

Optional Feature:
- Macro: STIM_WATCHDOG_EN.
- With the macro defined: a watchdog counter runs in RUN and DRAIN and clears on each pulse completion. On reaching TIMEOUT, or if gen_a and gen_b are high together, the block:
  - drops gen_enable and ch_sel the same cycle;
  - sets fault = 1;
  - enters FAULT, which is left only by reset.
- Without the macro: no watchdog logic, fault tied 0, FAULT state unreachable.

Decomposition:
- Shared package stim_pkg holds the state enum typedef, the default DEAD_TIME/TIMEOUT localparams and a onehot encode function.
- One natural sub-module: rr_arbiter (NCH-wide, pointer input, winner index plus valid output).

Test Plan:
- NCH=4, PULSES_PER_SLOT=2, DEAD_TIME=3, req=4'b0101 held, paired with a real generator model → grants ch0, ch2, ch0 in order. In each slot, exactly 2 B pulses are seen between enable rise and fall. slot_done pulses with slot_ch=0, 2, 0. ch_sel changes only while gen_enable has been 0 for ≥3 cycles.
- req[1] drops during the second NEG phase → POS2 completes, gen_enable falls on the gen_a falling edge, and slot_done fires with slot_ch=1 after DRAIN + 3 cycles.
- reset low for 1 cycle in RUN → next cycle gen_enable=0, ch_sel=0, busy=0. After release, arbitration restarts from ch0.
- req all zero after a slot → stays IDLE, busy=0, gen_enable=0 indefinitely.
- STIM_WATCHDOG_EN, TIMEOUT=100, generator held in reset during RUN → fault=1 at cycle 100, outputs cleared, FAULT held until reset.
- STIM_WATCHDOG_EN, gen_a=gen_b=1 injected → fault=1 the next cycle.
